dino_jump_controller: RTL and testbench

//  Per-frame dino physics stage feeding the VGA renderer's dino_x/dino_y inputs.

---
 rtl/dino_jump_controller_pkg.sv | 21 ++
 rtl/dino_jump_controller_if.sv | 32 +++
 rtl/dino_jump_controller_button_sync.sv | 31 +++
 rtl/dino_jump_controller.sv | 161 ++++++++++++++++
 tb/tb_dino_jump_controller.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dino_jump_controller_pkg.sv
// Shared constants and state type for the dino physics stage.
// The VGA renderer imports the same GROUND so that the sprite and the
// drawn ground line always agree.
//   DINO_X  : fixed left edge of the dino sprite (px)
//   GROUND  : ground line y (px)
//   DINO_H  : dino sprite height (px)
//   dino_state_t : motion state of the dino
package dino_pkg;

    localparam int unsigned DINO_X = 50;
    localparam int unsigned GROUND = 335;
    localparam int unsigned DINO_H = 60;

    typedef enum logic [1:0] {
        ST_GROUND,
        ST_DUCK,
        ST_ASCEND,
        ST_DESCEND
    } dino_state_t;

endpackage

// File: rtl/dino_jump_controller_if.sv
// Signal bundle between the game logic and the dino physics stage.
//   screenEnd : frame boundary pulse from VGA timing (multi-cycle high)
//   up        : raw jump button
//   down      : raw duck / fast-fall button
//   game_over : collision latch from the renderer (clk domain)
//   dino_x    : sprite left x (constant)
//   dino_y    : sprite top y
//   airborne  : dino is rising or falling
//   ducking   : dino is ducking on the ground
// master drives the inputs of the physics stage, slave is the physics stage.
interface dino_jump_controller_if;

    logic        screenEnd;
    logic        up;
    logic        down;
    logic        game_over;
    logic [31:0] dino_x;
    logic [31:0] dino_y;
    logic        airborne;
    logic        ducking;

    modport master (
        output screenEnd, up, down, game_over,
        input  dino_x, dino_y, airborne, ducking
    );

    modport slave (
        input  screenEnd, up, down, game_over,
        output dino_x, dino_y, airborne, ducking
    );

endinterface

// File: rtl/dino_jump_controller_button_sync.sv
// Two-flop synchroniser with a registered rising-edge detector.
//   clk   : system clock
//   reset : asynchronous, active-low
//   din   : raw asynchronous input
//   level : synchronised level
//   rise  : one-cycle pulse on each synchronised 0->1 transition
module button_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [1:0] sync;
    logic       prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            prev <= sync[1];
        end
    end

    assign level = sync[1];
    assign rise  = sync[1] & ~prev;

endmodule

// File: rtl/dino_jump_controller.sv
// Per-frame dino physics stage. Converts the up/down buttons into jump,
// fast-fall and duck motion, advancing once per video frame, and freezes
// while game_over is high.
//   clk   : 100 MHz system clock
//   reset : asynchronous, active-low
//   bus   : slave side of dino_jump_controller_if
//           (screenEnd/up/down/game_over in, dino_x/dino_y/airborne/ducking out)
// Height h is measured upward from the ground; dino_y = GROUND-DINO_H-h.
module dino_jump_controller
    import dino_pkg::*;
#(
    parameter int unsigned JUMP_VEL  = 16,
    parameter int unsigned GRAVITY   = 1,
    parameter int unsigned FAST_MULT = 3,
    parameter int unsigned MAX_FALL  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    dino_jump_controller_if.slave  bus
);

    localparam logic [5:0]  VEL0     = 6'(JUMP_VEL);
    localparam logic [5:0]  G_SLOW   = 6'(GRAVITY);
    localparam logic [5:0]  G_FAST   = 6'(GRAVITY * FAST_MULT);
    localparam logic [5:0]  FALL_MAX = 6'(MAX_FALL);
    localparam logic [31:0] Y_GROUND = 32'(GROUND - DINO_H);

    // A full jump must stay on screen and the speeds must fit their fields.
    if (JUMP_VEL * (JUMP_VEL + 1) / 2 > GROUND - DINO_H) begin : g_peak_check
        $error("dino_jump_controller: jump peak exceeds GROUND-DINO_H");
    end
    if (JUMP_VEL > 63 || MAX_FALL > 63 || GRAVITY * FAST_MULT > 63) begin : g_width_check
        $error("dino_jump_controller: speed parameter exceeds 6 bits");
    end

    // Input conditioning
    logic up_level, up_rise;
    logic down_s, down_rise;
    logic frame_level, tick;

    button_sync u_up_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.up),
        .level (up_level),
        .rise  (up_rise)
    );

    button_sync u_down_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.down),
        .level (down_s),
        .rise  (down_rise)
    );

    // screenEnd stays high for several cycles; only its leading edge advances a frame.
    button_sync u_frame_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.screenEnd),
        .level (frame_level),
        .rise  (tick)
    );

    logic sync_unused;
    assign sync_unused = &{1'b0, up_level, down_rise, frame_level};

    // Physics state
    dino_state_t state;
    logic [8:0]  h;
    logic [5:0]  vel;
    logic [5:0]  fall;
    logic        pending;

    logic [31:0] dino_y_r;
    logic        airborne_r;
    logic        ducking_r;

    // Per-frame step quantities
    logic [5:0] g;
    logic [5:0] vel_next;
    logic [6:0] fall_sum;
    logic [5:0] step;
    logic       grounded;

    always_comb begin
        g        = down_s ? G_FAST : G_SLOW;
        vel_next = (vel > g) ? (vel - g) : '0;
        fall_sum = {1'b0, fall} + {1'b0, g};
        step     = (fall_sum > {1'b0, FALL_MAX}) ? FALL_MAX : fall_sum[5:0];
        grounded = (state == ST_GROUND) || (state == ST_DUCK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_GROUND;
            h          <= '0;
            vel        <= '0;
            fall       <= '0;
            pending    <= 1'b0;
            dino_y_r   <= Y_GROUND;
            airborne_r <= 1'b0;
            ducking_r  <= 1'b0;
        end else begin
            // Outputs trail the state by one cycle; with state frozen they hold too.
            dino_y_r   <= Y_GROUND - {23'b0, h};
            airborne_r <= (state == ST_ASCEND) || (state == ST_DESCEND);
            ducking_r  <= (state == ST_DUCK);

            if (!bus.game_over) begin
                // A press on a tick cycle is latched here, but the tick below
                // still sees the old pending, so the jump starts a frame later.
                if (up_rise && grounded) begin
                    pending <= 1'b1;
                end

                if (tick) begin
                    unique case (state)
                        ST_GROUND, ST_DUCK: begin
                            if (pending) begin
                                state   <= ST_ASCEND;
                                vel     <= VEL0;
                                pending <= 1'b0;
                            end else if (down_s) begin
                                state <= ST_DUCK;
                            end else begin
                                state <= ST_GROUND;
                            end
                        end
                        ST_ASCEND: begin
                            h   <= h + {3'b0, vel};
                            vel <= vel_next;
                            if (vel_next == '0) begin
                                state <= ST_DESCEND;
                                fall  <= '0;
                            end
                        end
                        ST_DESCEND: begin
                            if (h <= {3'b0, step}) begin
                                h     <= '0;
                                fall  <= '0;
                                state <= ST_GROUND;
                            end else begin
                                h    <= h - {3'b0, step};
                                fall <= step;
                            end
                        end
                        default: state <= ST_GROUND;
                    endcase
                end
            end
        end
    end

    assign bus.dino_x   = 32'(DINO_X);
    assign bus.dino_y   = dino_y_r;
    assign bus.airborne = airborne_r;
    assign bus.ducking  = ducking_r;

endmodule

// File: tb/tb_dino_jump_controller.sv
// Self-checking bench for dino_jump_controller: a frame-level height/speed
// model is compared against the DUT on every settled cycle, plus literal
// checks at the key points of each scenario.
module tb_dino_jump_controller;

    localparam int JV = 16;
    localparam int GR = 1;
    localparam int FM = 3;
    localparam int MF = 16;
    localparam int Y0 = 275;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic r_se = 1'b0, r_up = 1'b0, r_down = 1'b0, r_go = 1'b0;

    always #5 clk = ~clk;

    dino_jump_controller_if bus ();

    assign bus.screenEnd = r_se;
    assign bus.up        = r_up;
    assign bus.down      = r_down;
    assign bus.game_over = r_go;

    dino_jump_controller #(
        .JUMP_VEL  (JV),
        .GRAVITY   (GR),
        .FAST_MULT (FM),
        .MAX_FALL  (MF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    bit valid = 1'b0;

    // Model: height above ground, upward speed, last fall step, duck, queued jump.
    int m_h = 0, m_vel = 0, m_fall = 0;
    bit m_duck = 1'b0, m_pending = 1'b0;

    function automatic bit m_air();
        return (m_h > 0) || (m_vel > 0);
    endfunction

    task automatic m_clear();
        m_h = 0; m_vel = 0; m_fall = 0; m_duck = 1'b0; m_pending = 1'b0;
    endtask

    task automatic m_step(input bit with_up);
        bit was_ground;
        int g, st;
        was_ground = !m_air();
        if (r_go) return;
        g = r_down ? GR * FM : GR;
        if (was_ground) begin
            if (m_pending) begin
                m_vel = JV; m_pending = 1'b0; m_duck = 1'b0;
            end else begin
                m_duck = r_down;
            end
        end else if (m_vel > 0) begin
            m_h   = m_h + m_vel;
            m_vel = (m_vel > g) ? m_vel - g : 0;
            if (m_vel == 0) m_fall = 0;
        end else begin
            st = (m_fall + g > MF) ? MF : m_fall + g;
            if (m_h <= st) begin
                m_h = 0; m_fall = 0;
            end else begin
                m_h = m_h - st; m_fall = st;
            end
        end
        if (with_up && was_ground && !m_air()) m_pending = 1'b1;
    endtask

    always @(negedge clk) begin
        if (valid) begin
            vectors++;
            if (bus.dino_y !== 32'(Y0 - m_h) || bus.dino_x !== 32'd50 ||
                bus.airborne !== m_air() || bus.ducking !== m_duck) begin
                miscompares++;
                $display("FAIL model t=%0t dino_y=%0d req %0d dino_x=%0d req 50 airborne=%0b req %0b ducking=%0b req %0b",
                         $time, bus.dino_y, Y0 - m_h, bus.dino_x, bus.airborne, m_air(), bus.ducking, m_duck);
            end
        end
    end

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic frame(input bit with_up);
        @(negedge clk);
        valid = 1'b0;
        m_step(with_up);
        r_se = 1'b1;
        if (with_up) r_up = 1'b1;
        repeat (4) @(negedge clk);
        r_se = 1'b0;
        repeat (4) @(negedge clk);
        valid = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(1'b0);
    endtask

    task automatic press_up(input bit hold);
        r_up = 1'b1;
        if (!r_go && !m_air()) m_pending = 1'b1;
        repeat (4) @(negedge clk);
        if (!hold) begin
            r_up = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid = 1'b0;
        r_up = 1'b0; r_down = 1'b0; r_go = 1'b0; r_se = 1'b0;
        reset = 1'b0;
        m_clear();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        valid = 1'b1;
    endtask

    initial begin
        #100000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset values and idle frames
        #2 reset = 1'b0;
        #1;
        pin("reset dino_x", bus.dino_x, 32'd50);
        pin("reset dino_y", bus.dino_y, 32'd275);
        pin("reset airborne", 32'(bus.airborne), 32'd0);
        pin("reset ducking", 32'(bus.ducking), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        valid = 1'b1;
        frames(3);
        pin("idle dino_y", bus.dino_y, 32'd275);

        // 2: single jump, peak at tick16, landing at tick32
        press_up(1'b0);
        frame(1'b0);
        pin("jump start airborne", 32'(bus.airborne), 32'd1);
        for (int i = 1; i <= 32; i++) begin
            frame(1'b0);
            if (i == 1)  pin("tick1 dino_y", bus.dino_y, 32'd259);
            if (i == 16) pin("tick16 peak dino_y", bus.dino_y, 32'd139);
            if (i == 31) pin("tick31 airborne", 32'(bus.airborne), 32'd1);
            if (i == 32) begin
                pin("tick32 dino_y", bus.dino_y, 32'd275);
                pin("tick32 airborne", 32'(bus.airborne), 32'd0);
            end
        end
        frames(2);

        // 3: up held for 100 frames gives exactly one jump
        press_up(1'b1);
        frames(100);
        pin("held up grounded", 32'(bus.airborne), 32'd0);
        pin("held up dino_y", bus.dino_y, 32'd275);
        r_up = 1'b0;
        frames(1);

        // 4: fast fall from the peak, clamp at 16, then duck on ground
        press_up(1'b0);
        frame(1'b0);
        frames(16);
        r_down = 1'b1;
        for (int i = 17; i <= 28; i++) begin
            frame(1'b0);
            if (i == 17) pin("fast fall step3 dino_y", bus.dino_y, 32'd142);
            if (i == 22) pin("fast fall clamp dino_y", bus.dino_y, 32'd200);
            if (i == 23) pin("fast fall clamp2 dino_y", bus.dino_y, 32'd216);
            if (i == 27) pin("fast fall landed airborne", 32'(bus.airborne), 32'd0);
            if (i == 28) begin
                pin("duck ducking", 32'(bus.ducking), 32'd1);
                pin("duck dino_y", bus.dino_y, 32'd275);
            end
        end
        r_down = 1'b0;
        frames(1);
        pin("unduck ducking", 32'(bus.ducking), 32'd0);

        // 5: game_over freezes mid-ascent
        press_up(1'b0);
        frame(1'b0);
        frames(8);
        pin("tick8 dino_y", bus.dino_y, 32'd175);
        r_go = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 0) press_up(1'b0);
            frame(1'b0);
        end
        pin("game_over hold dino_y", bus.dino_y, 32'd175);
        do_reset();

        // 6: asynchronous reset mid-ascent
        press_up(1'b0);
        frame(1'b0);
        frames(5);
        pin("pre-reset dino_y", bus.dino_y, 32'd205);
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        pin("async reset dino_y", bus.dino_y, 32'd275);
        pin("async reset airborne", 32'(bus.airborne), 32'd0);
        m_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        valid = 1'b1;

        // 7: up edge on the tick cycle jumps one frame later
        frame(1'b1);
        pin("same-tick up airborne", 32'(bus.airborne), 32'd0);
        r_up = 1'b0;
        frame(1'b0);
        pin("next-tick jump airborne", 32'(bus.airborne), 32'd1);
        frames(32);
        pin("same-tick jump landed", 32'(bus.airborne), 32'd0);
        r_down = 1'b1;
        frame(1'b0);
        pin("ground down ducking", 32'(bus.ducking), 32'd1);
        pin("ground down dino_y", bus.dino_y, 32'd275);
        r_down = 1'b0;
        frames(1);

        valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
